// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
// Immediate generator with a small output FIFO. Each accepted instruction is
// decoded into a sign-extended immediate plus an "illegal format" flag and is
// queued; the head entry is presented with a valid/ready handshake.
//
// Ports
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_flush              drop every buffered entry at the next edge
//   i_valid / o_ready    input handshake (o_ready depends on state only)
//   i_instr              32-bit instruction word
//   i_imm_sel            format select (unused when AUTO_DECODE=1)
//   o_valid / i_ready    output handshake for the head entry
//   o_imm, o_illegal     head entry contents
//   o_count              number of occupied entries
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN        = 32,
    parameter int AUTO_DECODE = 0,
    parameter int DEPTH       = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [31:0]                i_instr,
    input  logic [2:0]                 i_imm_sel,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [XLEN-1:0]            o_imm,
    output logic                       o_illegal,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] FMT_R  = 3'b000;
    localparam logic [2:0] FMT_I  = 3'b001;
    localparam logic [2:0] FMT_B  = 3'b010;
    localparam logic [2:0] FMT_J1 = 3'b011;
    localparam logic [2:0] FMT_J2 = 3'b100;
    localparam logic [2:0] FMT_U  = 3'b101;
    localparam logic [2:0] FMT_S  = 3'b111;

    // ------------------------------------------------------------------
    // Format selection
    // ------------------------------------------------------------------
    logic [2:0] fmt;

    always_comb begin
        fmt = i_imm_sel;
        if (AUTO_DECODE != 0) begin
            case (i_instr[6:0])
                7'b0110011:                         fmt = FMT_R;
                7'b0010011, 7'b0000011, 7'b1110011: fmt = FMT_I;
                7'b1100111:                         fmt = FMT_J2;
                7'b1100011:                         fmt = FMT_B;
                7'b1101111:                         fmt = FMT_J1;
                7'b0110111, 7'b0010111:             fmt = FMT_U;
                7'b0100011:                         fmt = FMT_S;
                default:                            fmt = 3'b110;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Immediate extraction. Every non-zero format carries instr[31] in
    // bit 31 of imm32, so a signed widen gives the required extension.
    // ------------------------------------------------------------------
    logic [31:0]     imm32;
    logic            ill_dec;
    logic [XLEN-1:0] imm_dec;

    always_comb begin
        imm32   = 32'd0;
        ill_dec = 1'b0;
        case (fmt)
            FMT_R:  imm32 = 32'd0;
            FMT_I,
            FMT_J2: imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S:  imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B:  imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                             i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_J1: imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                             i_instr[20], i_instr[30:21], 1'b0};
            FMT_U:  imm32 = {i_instr[31:12], 12'd0};
            default: begin
                imm32   = 32'd0;
                ill_dec = 1'b1;
            end
        endcase
        imm_dec = XLEN'($signed(imm32));
    end

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    logic [XLEN-1:0] imm_q [DEPTH];
    logic            ill_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            push, pop;

    assign o_ready   = (count_q < CW'(DEPTH));
    assign o_valid   = (count_q != '0);
    assign o_count   = count_q;
    assign o_imm     = imm_q[rd_ptr_q];
    assign o_illegal = ill_q[rd_ptr_q];

    // Flush suppresses both handshakes so it wins over a same-cycle transfer.
    assign push = i_valid && o_ready && !i_flush;
    assign pop  = o_valid && i_ready && !i_flush;

    // Pointers are exactly PW bits wide, so +1 wraps modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head reads zero while empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                imm_q[i] <= '0;
                ill_q[i] <= 1'b0;
            end
        end else if (push) begin
            imm_q[wr_ptr_q] <= imm_dec;
            ill_q[wr_ptr_q] <= ill_dec;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT A: defaults (XLEN=32, AUTO_DECODE=0, DEPTH=2)
    logic        a_flush, a_valid, a_iready;
    logic [31:0] a_instr;
    logic [2:0]  a_sel;
    logic        a_oready, a_ovalid, a_ill;
    logic [31:0] a_imm;
    logic [1:0]  a_cnt;

    // DUT B: XLEN=64, AUTO_DECODE=1, DEPTH=4
    logic        b_flush, b_valid, b_iready;
    logic [31:0] b_instr;
    logic [2:0]  b_sel;
    logic        b_oready, b_ovalid, b_ill;
    logic [63:0] b_imm;
    logic [2:0]  b_cnt;

    imm_gen_pipe u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(a_flush),
        .i_valid(a_valid), .o_ready(a_oready), .i_instr(a_instr),
        .i_imm_sel(a_sel), .o_valid(a_ovalid), .i_ready(a_iready),
        .o_imm(a_imm), .o_illegal(a_ill), .o_count(a_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1), .DEPTH(4)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(b_flush),
        .i_valid(b_valid), .o_ready(b_oready), .i_instr(b_instr),
        .i_imm_sel(b_sel), .o_valid(b_ovalid), .i_ready(b_iready),
        .o_imm(b_imm), .o_illegal(b_ill), .o_count(b_cnt)
    );

    int tests = 0;
    int fails = 0;

    logic [32:0] qa [$];   // {imm32, illegal}
    logic [64:0] qb [$];   // {imm64, illegal}

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: compare the head whenever a pop is about to happen.
    always @(negedge clk) begin
        if (rst_n && a_ovalid && a_iready && !a_flush) begin
            tests++;
            if (qa.size() == 0) begin
                fails++;
                $display("FAIL a_unexpected: got imm=%h ill=%b expected no entry", a_imm, a_ill);
            end else begin
                logic [32:0] e;
                e = qa.pop_front();
                if ({a_imm, a_ill} !== e) begin
                    fails++;
                    $display("FAIL a_entry: got imm=%h ill=%b expected imm=%h ill=%b",
                             a_imm, a_ill, e[32:1], e[0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_ovalid && b_iready && !b_flush) begin
            tests++;
            if (qb.size() == 0) begin
                fails++;
                $display("FAIL b_unexpected: got imm=%h ill=%b expected no entry", b_imm, b_ill);
            end else begin
                logic [64:0] e;
                e = qb.pop_front();
                if ({b_imm, b_ill} !== e) begin
                    fails++;
                    $display("FAIL b_entry: got imm=%h ill=%b expected imm=%h ill=%b",
                             b_imm, b_ill, e[64:1], e[0]);
                end
            end
        end
    end

    // Drivers: called at posedge+1, return at posedge+1 after acceptance.
    task automatic send_a(input logic [31:0] instr, input logic [2:0] sel,
                          input logic [31:0] imm, input logic ill);
        int n = 0;
        a_valid = 1'b1; a_instr = instr; a_sel = sel;
        while (!a_oready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!a_oready) begin
            tests++; fails++;
            $display("FAIL a_accept_timeout: got o_ready=0 expected 1");
        end else begin
            qa.push_back({imm, ill});
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] instr, input logic [63:0] imm, input logic ill);
        int n = 0;
        b_valid = 1'b1; b_instr = instr;
        while (!b_oready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!b_oready) begin
            tests++; fails++;
            $display("FAIL b_accept_timeout: got o_ready=0 expected 1");
        end else begin
            qb.push_back({imm, ill});
            @(posedge clk); #1;
        end
        b_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d/%0d left expected 0/0", qa.size(), qb.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_flush = 0; a_valid = 0; a_iready = 0; a_instr = '0; a_sel = '0;
        b_flush = 0; b_valid = 0; b_iready = 0; b_instr = '0; b_sel = '0;
        #7;
        chk("rst_count",   64'(a_cnt),    64'd0);
        chk("rst_valid",   64'(a_ovalid), 64'd0);
        chk("rst_ready",   64'(a_oready), 64'd1);
        chk("rst_imm",     64'(a_imm),    64'd0);
        chk("rst_illegal", 64'(a_ill),    64'd0);
        chk("rst_b_valid", 64'(b_ovalid), 64'd0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        a_iready = 1'b1;

        // First push on the first edge after release, visible one cycle later.
        send_a(32'hFFF00093, 3'b001, 32'hFFFFFFFF, 1'b0);
        chk("first_valid", 64'(a_ovalid), 64'd1);
        chk("first_count", 64'(a_cnt),    64'd1);

        // All formats back-to-back with the consumer ready: count stays at 1.
        send_a(32'hFFFFFFFF, 3'b000, 32'h00000000, 1'b0);
        send_a(32'h12345678, 3'b110, 32'h00000000, 1'b1);
        send_a(32'hFE000EE3, 3'b010, 32'hFFFFFFFC, 1'b0);
        send_a(32'h0080006F, 3'b011, 32'h00000008, 1'b0);
        chk("steady_count", 64'(a_cnt), 64'd1);
        send_a(32'h7FF00000, 3'b100, 32'h000007FF, 1'b0);
        send_a(32'h800000B7, 3'b101, 32'h80000000, 1'b0);
        send_a(32'h00A12423, 3'b111, 32'h00000008, 1'b0);
        send_a(32'hFE112E23, 3'b111, 32'hFFFFFFFC, 1'b0);
        send_a(32'h0000007F, 3'b101, 32'h00000000, 1'b0);
        wait_drain();
        chk("a_empty", 64'(a_cnt), 64'd0);

        // Backpressure on DEPTH=2: third push stalls until a slot frees.
        a_iready = 1'b0;
        fork
            begin
                send_a(32'h00100093, 3'b001, 32'h00000001, 1'b0);
                send_a(32'h00200093, 3'b001, 32'h00000002, 1'b0);
                send_a(32'h00300093, 3'b001, 32'h00000003, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("full_count", 64'(a_cnt),    64'd2);
                chk("full_ready", 64'(a_oready), 64'd0);
                chk("full_head",  64'(a_imm),    64'd1);
                a_iready = 1'b1;
                #1;
                chk("full_ready_pop", 64'(a_oready), 64'd0);
            end
        join
        wait_drain();

        // DUT B: fill all four slots, then stream with wrap-around.
        b_iready = 1'b0;
        send_b(32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send_b(32'h0080006F, 64'h0000000000000008, 1'b0);
        send_b(32'h800000B7, 64'hFFFFFFFF80000000, 1'b0);
        send_b(32'h0000007F, 64'h0000000000000000, 1'b1);
        chk("b_full_count", 64'(b_cnt),    64'd4);
        chk("b_full_ready", 64'(b_oready), 64'd0);
        chk("b_head",       b_imm,         64'hFFFFFFFFFFFFFFFC);
        b_iready = 1'b1;
        send_b(32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        send_b(32'h00000033, 64'h0000000000000000, 1'b0);
        send_b(32'hFFC08067, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send_b(32'h12345017, 64'h0000000012345000, 1'b0);
        send_b(32'h80002083, 64'hFFFFFFFFFFFFF800, 1'b0);
        send_b(32'h30002573, 64'h0000000000000300, 1'b0);
        send_b(32'hFFDFF06F, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send_b(32'hFE112E23, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        wait_drain();

        // Flush with simultaneous push and pop at count=1.
        a_iready = 1'b0;
        send_a(32'h00500093, 3'b001, 32'h00000005, 1'b0);
        chk("pre_flush_count", 64'(a_cnt), 64'd1);
        a_valid = 1'b1; a_instr = 32'h00600093; a_sel = 3'b001;
        a_iready = 1'b1; a_flush = 1'b1;
        @(posedge clk); #1;
        a_flush = 1'b0; a_valid = 1'b0;
        qa.delete();
        chk("flush_count", 64'(a_cnt),    64'd0);
        chk("flush_valid", 64'(a_ovalid), 64'd0);

        // Asynchronous reset mid-stream.
        a_iready = 1'b0;
        send_a(32'h00700093, 3'b001, 32'h00000007, 1'b0);
        send_a(32'h00800093, 3'b001, 32'h00000008, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(a_ovalid), 64'd0);
        chk("arst_ready", 64'(a_oready), 64'd1);
        chk("arst_count", 64'(a_cnt),    64'd0);
        chk("arst_imm",   64'(a_imm),    64'd0);
        qa.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_a(32'h00900093, 3'b001, 32'h00000009, 1'b0);
        chk("post_rst_count", 64'(a_cnt), 64'd1);
        a_iready = 1'b1;
        wait_drain();
        @(posedge clk); #1;
        chk("final_valid", 64'(a_ovalid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, output immediate width; legal values 32 and 64.
REQ-002 SHALL have parameter AUTO_DECODE, default 0:
- 0: format taken from in_imm_sel.
- 1: format derived from instruction opcode bits [6:0].
REQ-003 SHALL have parameter DEPTH, default 2, output buffer entries; power of two, 2..8.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, named as the codebase names them:
- i_clk      input   1      clock; all state updates on rising edge.
- i_rst_n    input   1      reset; asynchronous, active-low.
REQ-005 SHALL have the remaining ports:
- i_flush      input   1                  discard all buffered entries.
- i_valid      input   1                  input instruction valid.
- o_ready      output  1                  buffer can accept an input.
- i_instr      input   32                 instruction word.
- i_imm_sel    input   3                  format select; ignored when AUTO_DECODE=1.
- o_valid      output  1                  head entry valid.
- i_ready      input   1                  consumer accepts head entry.
- o_imm        output  XLEN               immediate of head entry.
- o_illegal    output  1                  head entry had a reserved format.
- o_count      output  $clog2(DEPTH)+1    occupied entries.

Function
REQ-006 Format encoding SHALL be: R=000, I=001, B=010, J1=011 (JAL), J2=100 (JALR), U=101, S=111; 110 is reserved.
REQ-007 Immediate bit fields SHALL be as follows, all sign-extended from i_instr[31] to XLEN:
- R: zero.
- I and J2: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- J1: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- U: {instr[31:12], 12'b0}.
REQ-008 The reserved format SHALL produce imm=0 with illegal=1; every other format SHALL produce illegal=0.
REQ-009 With AUTO_DECODE=1, opcodes SHALL map to formats as follows:
- 0110011 -> R.
- 0010011, 0000011, 1110011 -> I.
- 1100111 -> J2.
- 1100011 -> B.
- 1101111 -> J1.
- 0110111, 0010111 -> U.
- 0100011 -> S.
- any other opcode -> reserved.
REQ-010 A push SHALL occur when i_valid && o_ready && !i_flush; the decoded {imm, illegal} is written at the tail.
REQ-011 A pop SHALL occur when o_valid && i_ready && !i_flush; the head advances.
REQ-012 o_ready SHALL be (o_count < DEPTH), registered-state based, with no combinational path from i_ready.
REQ-013 When full, a same-cycle pop SHALL NOT enable a push; o_ready stays low that cycle.
REQ-014 A simultaneous push and pop when 0 < count < DEPTH SHALL leave count unchanged.
REQ-015 o_valid SHALL equal (o_count != 0); o_imm and o_illegal SHALL reflect the head entry combinationally from storage.
REQ-016 Latency SHALL be 1 cycle (input accepted at edge N -> o_valid high after edge N); throughput SHALL be 1 entry per cycle.
REQ-017 Read and write pointers SHALL wrap modulo DEPTH.
REQ-018 i_flush SHALL set count and both pointers to 0 at the next edge, overriding any push and pop that cycle.
REQ-019 While o_valid && !i_ready, the head entry (o_imm, o_illegal) SHALL remain stable.
REQ-020 For XLEN=64, U and J1 immediates SHALL be sign-extended through bit 63.

Reset
REQ-021 On i_rst_n low, asynchronously: o_count=0, o_valid=0, o_ready=1, pointers=0, o_imm=0, o_illegal=0.
REQ-022 Reset asserted mid-transfer SHALL discard all entries; no entry is presented after release.
REQ-023 The first push SHALL be accepted on the first rising edge after i_rst_n deasserts.

Verification
REQ-024 AUTO_DECODE=0, sel=001, instr 0xFFF00093 -> next cycle o_valid=1, o_imm=0xFFFFFFFF, o_illegal=0.
REQ-025 AUTO_DECODE=1, instr 0xFE000EE3 (beq -4) -> o_imm=0xFFFFFFFC; instr 0x0080006F (jal 8) -> o_imm=0x00000008.
REQ-026 XLEN=64, AUTO_DECODE=1, instr 0x800000B7 -> o_imm=0xFFFFFFFF80000000; instr 0x0000007F -> o_imm=0, o_illegal=1.
REQ-027 DEPTH=2, i_ready=0, push 3 back-to-back -> o_count=2, o_ready=0, third input not accepted; raise i_ready -> entries drain in order, and the third is accepted once o_ready returns to 1.
REQ-028 Count=1 with simultaneous push, pop and i_flush -> next cycle o_count=0, o_valid=0; drop i_rst_n mid-stream -> immediate o_valid=0, o_ready=1.
